// File: rtl/hit_pkg.sv
// Shared types and constants for the hit scorer: FSM encoding, widths,
// coordinate constants and saturation helpers.
package hit_pkg;

    typedef enum logic [1:0] {
        ARMED    = 2'd0,
        CONFIRM  = 2'd1,
        ACK      = 2'd2,
        COOLDOWN = 2'd3
    } hit_state_e;

    localparam int COORD_W     = 12;
    localparam int SCORE_W     = 14;
    localparam int FRAME_CNT_W = 16;

    localparam logic [COORD_W-1:0] RESET_X      = 12'd320;
    localparam logic [COORD_W-1:0] RESET_Y      = 12'd240;
    localparam logic [COORD_W-1:0] COORD_OFFSET = 12'd64;
    localparam logic [SCORE_W-1:0] SCORE_MAX    = 14'd9999;

    // X spans 64..575, Y spans 64..319.
    function automatic logic [COORD_W-1:0] coord_x(input logic [15:0] l);
        return COORD_OFFSET + {3'b000, l[8:0]};
    endfunction

    function automatic logic [COORD_W-1:0] coord_y(input logic [15:0] l);
        return COORD_OFFSET + {4'b0000, l[15:8]};
    endfunction

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v < SCORE_MAX) ? v + 14'd1 : SCORE_MAX;
    endfunction

endpackage

// File: rtl/hit_scorer_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), free-running every clock.
module lfsr16 (
    input  logic        clk,
    input  logic        resetn,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;

    always_comb begin
        q_d = {q_q[14:0], q_q[15] ^ q_q[13] ^ q_q[12] ^ q_q[10]};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            q_q <= seed;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/hit_scorer.sv
// Frame-based hit confirmation, cooldown and miss timeout for a moving target.
// hitAck is a single-cycle pulse, high exactly while the FSM is in ACK.
module hit_scorer
    import hit_pkg::*;
#(
    parameter int          HIT_FRAMES      = 3,
    parameter int          COOLDOWN_FRAMES = 30,
    parameter int          TIMEOUT_FRAMES  = 300,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               frame_tick,
    input  logic               hit,
    output logic               hitAck,
    output logic [COORD_W-1:0] targetCoord_X,
    output logic [COORD_W-1:0] targetCoord_Y,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] misses,
    output logic               armed,
    output hit_state_e         state_dbg
);

    localparam logic [FRAME_CNT_W-1:0] HIT_LIM  = FRAME_CNT_W'(HIT_FRAMES);
    localparam logic [FRAME_CNT_W-1:0] COOL_LIM = FRAME_CNT_W'(COOLDOWN_FRAMES);
    localparam logic [FRAME_CNT_W-1:0] TMO_LIM  = FRAME_CNT_W'(TIMEOUT_FRAMES);

    hit_state_e               state_q, state_d;
    logic [FRAME_CNT_W-1:0]   confirm_q, confirm_d;
    logic [FRAME_CNT_W-1:0]   cool_q, cool_d;
    logic [FRAME_CNT_W-1:0]   tmo_q, tmo_d;
    logic [SCORE_W-1:0]       score_q, score_d;
    logic [SCORE_W-1:0]       miss_q, miss_d;
    logic [COORD_W-1:0]       x_q, x_d;
    logic [COORD_W-1:0]       y_q, y_d;
    logic                     hit_ack_q, hit_ack_d;
    logic                     armed_q, armed_d;
    logic [15:0]              lfsr;

    lfsr16 u_lfsr (
        .clk    (clk),
        .resetn (resetn),
        .seed   (LFSR_SEED),
        .q      (lfsr)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ARMED;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the frame counters and score/miss datapath it steers.
    always_comb begin
        state_d   = state_q;
        confirm_d = confirm_q;
        cool_d    = cool_q;
        tmo_d     = tmo_q;
        score_d   = score_q;
        miss_d    = miss_q;
        x_d       = x_q;
        y_d       = y_q;
        case (state_q)
            ARMED: begin
                if (frame_tick) begin
                    if (hit) begin
                        confirm_d = 16'd1;
                        state_d   = (HIT_LIM <= 16'd1) ? ACK : CONFIRM;
                    end else if (tmo_q + 16'd1 >= TMO_LIM) begin
                        miss_d = sat_inc(miss_q);
                        x_d    = coord_x(lfsr);
                        y_d    = coord_y(lfsr);
                        tmo_d  = '0;
                    end else begin
                        tmo_d = tmo_q + 16'd1;
                    end
                end
            end
            CONFIRM: begin
                if (frame_tick) begin
                    if (hit) begin
                        confirm_d = confirm_q + 16'd1;
                        if (confirm_q + 16'd1 >= HIT_LIM) begin
                            state_d = ACK;
                        end
                    end else begin
                        confirm_d = '0;
                        state_d   = ARMED;
                    end
                end
            end
            ACK: begin
                score_d   = sat_inc(score_q);
                x_d       = coord_x(lfsr);
                y_d       = coord_y(lfsr);
                confirm_d = '0;
                cool_d    = '0;
                state_d   = COOLDOWN;
            end
            COOLDOWN: begin
                if (frame_tick) begin
                    cool_d = cool_q + 16'd1;
                    if (cool_q + 16'd1 >= COOL_LIM) begin
                        cool_d  = '0;
                        tmo_d   = '0;
                        state_d = ARMED;
                    end
                end
            end
            default: state_d = ARMED;
        endcase
    end

    // Flag outputs are registered from the next state so they line up with state_q.
    always_comb begin
        hit_ack_d = (state_d == ACK);
        armed_d   = (state_d == ARMED);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            confirm_q <= '0;
            cool_q    <= '0;
            tmo_q     <= '0;
            score_q   <= '0;
            miss_q    <= '0;
            x_q       <= RESET_X;
            y_q       <= RESET_Y;
            hit_ack_q <= 1'b0;
            armed_q   <= 1'b1;
        end else begin
            confirm_q <= confirm_d;
            cool_q    <= cool_d;
            tmo_q     <= tmo_d;
            score_q   <= score_d;
            miss_q    <= miss_d;
            x_q       <= x_d;
            y_q       <= y_d;
            hit_ack_q <= hit_ack_d;
            armed_q   <= armed_d;
        end
    end

    assign hitAck        = hit_ack_q;
    assign armed         = armed_q;
    assign score         = score_q;
    assign misses        = miss_q;
    assign targetCoord_X = x_q;
    assign targetCoord_Y = y_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_hit_scorer.sv
// Directed bench for hit_scorer: confirm/abort, cooldown, timeout, hit-vs-timeout,
// reset priority, and score saturation on a fast-configured second instance.
module tb_hit_scorer;
    import hit_pkg::*;

    logic        clk;
    logic        resetn;
    logic        frame_tick;
    logic        hit;
    logic        hit_ack;
    logic [11:0] tx, ty;
    logic [13:0] score, misses;
    logic        armed;
    hit_state_e  state_dbg;

    logic        sat_tick, sat_hit, sat_ack, sat_armed;
    logic [11:0] sat_x, sat_y;
    logic [13:0] sat_score, sat_misses;
    hit_state_e  sat_state;

    int total = 0;
    int bad   = 0;
    int ack_cnt = 0;

    // Clock and reset drive
    initial clk = 1'b0;
    always #5 clk = ~clk;

    hit_scorer dut (
        .clk           (clk),
        .resetn        (resetn),
        .frame_tick    (frame_tick),
        .hit           (hit),
        .hitAck        (hit_ack),
        .targetCoord_X (tx),
        .targetCoord_Y (ty),
        .score         (score),
        .misses        (misses),
        .armed         (armed),
        .state_dbg     (state_dbg)
    );

    hit_scorer #(
        .HIT_FRAMES      (1),
        .COOLDOWN_FRAMES (1),
        .TIMEOUT_FRAMES  (300)
    ) u_sat (
        .clk           (clk),
        .resetn        (resetn),
        .frame_tick    (sat_tick),
        .hit           (sat_hit),
        .hitAck        (sat_ack),
        .targetCoord_X (sat_x),
        .targetCoord_Y (sat_y),
        .score         (sat_score),
        .misses        (sat_misses),
        .armed         (sat_armed),
        .state_dbg     (sat_state)
    );

    always @(posedge clk) begin
        if (hit_ack) ack_cnt <= ack_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One idle cycle, then a single-cycle tick; returns just after the tick edge.
    task automatic tick(input logic h);
        @(negedge clk);
        frame_tick = 1'b1;
        hit        = h;
        @(negedge clk);
        frame_tick = 1'b0;
        hit        = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        int n;
        int acks;
        resetn     = 1'b0;
        frame_tick = 1'b0;
        hit        = 1'b0;
        sat_tick   = 1'b0;
        sat_hit    = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_armed", 32'(armed), 1);
        chk("rst_state", 32'(state_dbg), 32'(ARMED));
        chk("rst_ack", 32'(hit_ack), 0);
        chk("rst_score", 32'(score), 0);
        chk("rst_misses", 32'(misses), 0);
        chk("rst_x", 32'(tx), 320);
        chk("rst_y", 32'(ty), 240);

        // Two hit ticks then a miss: abort back to ARMED
        tick(1'b1);
        chk("abort_confirm_state", 32'(state_dbg), 32'(CONFIRM));
        chk("abort_confirm_armed", 32'(armed), 0);
        tick(1'b1);
        tick(1'b0);
        chk("abort_state", 32'(state_dbg), 32'(ARMED));
        chk("abort_armed", 32'(armed), 1);
        chk("abort_score", 32'(score), 0);
        @(negedge clk);
        chk("abort_no_ack", 32'(ack_cnt), 0);

        // Three hit ticks: one ack, score 1, new target, 30-tick cooldown
        tick(1'b1);
        tick(1'b1);
        chk("hit2_no_ack", 32'(hit_ack), 0);
        tick(1'b1);
        chk("hit3_ack", 32'(hit_ack), 1);
        chk("hit3_state", 32'(state_dbg), 32'(ACK));
        @(negedge clk);
        chk("ack_one_cycle", 32'(hit_ack), 0);
        chk("ack_score", 32'(score), 1);
        chk("ack_coord_moved", 32'(tx != 12'd320 || ty != 12'd240), 1);
        chk("ack_x_range", 32'(tx >= 12'd64 && tx <= 12'd575), 1);
        chk("ack_y_range", 32'(ty >= 12'd64 && ty <= 12'd319), 1);
        chk("ack_state_cool", 32'(state_dbg), 32'(COOLDOWN));
        for (int i = 0; i < 29; i++) tick(1'b1);
        chk("cool29_armed", 32'(armed), 0);
        tick(1'b1);
        chk("cool30_armed", 32'(armed), 1);
        @(negedge clk);
        chk("cool_single_ack", 32'(ack_cnt), 1);
        chk("cool_score", 32'(score), 1);

        // Reset asserted on the confirming tick suppresses the ack
        tick(1'b1);
        tick(1'b1);
        @(negedge clk);
        frame_tick = 1'b1;
        hit        = 1'b1;
        resetn     = 1'b0;
        @(negedge clk);
        frame_tick = 1'b0;
        hit        = 1'b0;
        resetn     = 1'b1;
        chk("rstack_ack", 32'(hit_ack), 0);
        chk("rstack_armed", 32'(armed), 1);
        chk("rstack_score", 32'(score), 0);
        @(negedge clk);
        chk("rstack_ack_cnt", 32'(ack_cnt), 1);

        // Timeout: 300 empty ticks produce exactly one miss
        for (int i = 0; i < 299; i++) tick(1'b0);
        chk("tmo299_misses", 32'(misses), 0);
        chk("tmo299_x", 32'(tx), 320);
        tick(1'b0);
        chk("tmo300_misses", 32'(misses), 1);
        chk("tmo_state", 32'(state_dbg), 32'(ARMED));
        chk("tmo_x_range", 32'(tx >= 12'd64 && tx <= 12'd575), 1);
        chk("tmo_y_range", 32'(ty >= 12'd64 && ty <= 12'd319), 1);
        @(negedge clk);
        chk("tmo_no_ack", 32'(ack_cnt), 1);

        // Hit on the expiring tick wins over the timeout
        do_reset();
        for (int i = 0; i < 299; i++) tick(1'b0);
        tick(1'b1);
        chk("race_misses", 32'(misses), 0);
        chk("race_state", 32'(state_dbg), 32'(CONFIRM));
        tick(1'b1);
        tick(1'b1);
        chk("race_ack", 32'(hit_ack), 1);
        @(negedge clk);
        chk("race_score", 32'(score), 1);
        chk("race_misses_after", 32'(misses), 0);

        // One-cycle reset in the middle of cooldown
        for (int i = 0; i < 5; i++) tick(1'b1);
        chk("midcool_state", 32'(state_dbg), 32'(COOLDOWN));
        do_reset();
        chk("midrst_armed", 32'(armed), 1);
        chk("midrst_score", 32'(score), 0);
        chk("midrst_x", 32'(tx), 320);
        chk("midrst_y", 32'(ty), 240);
        chk("midrst_ack", 32'(hit_ack), 0);

        // Saturation: drive 9999 confirmed hits on the HIT_FRAMES=1 instance
        @(negedge clk);
        sat_tick = 1'b1;
        sat_hit  = 1'b1;
        n = 0;
        for (int c = 0; c < 40000 && n < 9999; c++) begin
            @(negedge clk);
            if (sat_ack) n++;
        end
        sat_tick = 1'b0;
        sat_hit  = 1'b0;
        chk("sat_pulses", 32'(n), 9999);
        @(negedge clk);
        chk("sat_score_max", 32'(sat_score), 9999);
        sat_tick = 1'b1;
        sat_hit  = 1'b1;
        acks = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (sat_ack) acks++;
        end
        sat_tick = 1'b0;
        sat_hit  = 1'b0;
        chk("sat_extra_ack", 32'(acks), 1);
        @(negedge clk);
        chk("sat_score_hold", 32'(sat_score), 9999);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hit_scorer.md
HIT_SCORER -- requirements
Module: hit_scorer

Interface
REQ-001 SHALL have parameter HIT_FRAMES, default 3, number of consecutive frames with hit high needed to confirm a hit.
REQ-002 SHALL have parameter COOLDOWN_FRAMES, default 30, number of frames after a confirmed hit during which hit is ignored.
REQ-003 SHALL have parameter TIMEOUT_FRAMES, default 300, number of frames the target may go unhit before it is relocated as a miss.
REQ-004 SHALL have parameter LFSR_SEED, default 16'hACE1, LFSR reset value (must be nonzero).
REQ-005 SHALL have port clk, input, 1, the single system clock; all logic is rising-edge.
REQ-006 SHALL have port resetn, input, 1, synchronous active-low reset.
REQ-007 SHALL have port frame_tick, input, 1, one-cycle strobe per video frame.
REQ-008 SHALL have port hit, input, 1, level overlap flag from the hit detector.
REQ-009 SHALL have port hitAck, output, 1, one-cycle pulse acknowledging a confirmed hit.
REQ-010 SHALL have ports targetCoord_X and targetCoord_Y, output, 12 each, current target centre fed to the hit detector and renderer.
REQ-011 SHALL have port score, output, 14, count of confirmed hits.
REQ-012 SHALL have port misses, output, 14, count of timeouts.
REQ-013 SHALL have port armed, output, 1, high only in state ARMED.

Function
REQ-014 SHALL implement the FSM states ARMED, CONFIRM, ACK and COOLDOWN.
REQ-015 SHALL sample hit only on cycles where frame_tick=1; all frame counters advance only on frame_tick.
REQ-016 In ARMED with hit=1 on a tick: go to CONFIRM and set confirm_cnt=1; if HIT_FRAMES=1, go directly to ACK.
REQ-017 In CONFIRM with hit=1 on a tick: increment confirm_cnt, and on reaching HIT_FRAMES go to ACK.
REQ-018 In CONFIRM with hit=0 on a tick: clear confirm_cnt and return to ARMED; the timeout counter is not cleared.
REQ-019 ACK SHALL last exactly one clk cycle, independent of frame_tick, and SHALL do all of the following:
- assert hitAck=1;
- increment score, saturating at 9999;
- load new target coordinates;
- then enter COOLDOWN with cooldown_cnt=0.
REQ-020 In COOLDOWN, hit SHALL be ignored; on the tick where cooldown_cnt reaches COOLDOWN_FRAMES, return to ARMED with the timeout counter cleared.
REQ-021 In ARMED, each tick with hit=0 SHALL increment timeout_cnt; on reaching TIMEOUT_FRAMES in the same cycle:
- increment misses, saturating at 9999;
- load new target coordinates;
- clear timeout_cnt;
- remain in ARMED.
REQ-022 If hit=1 arrives on the tick that would expire the timeout, the hit SHALL win: enter CONFIRM and do not count a miss.
REQ-023 A 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every clk cycle.
REQ-024 New coordinates SHALL be computed as:
- targetCoord_X = 64 + lfsr[8:0], range 64..575;
- targetCoord_Y = 64 + {1'b0, lfsr[15:8]}, range 64..319;
- both zero-extended to 12 bits.
REQ-025 targetCoord_X/Y SHALL change only on an ACK or timeout cycle and hold otherwise.
REQ-026 Outputs SHALL be registered (hitAck, armed, and counters driven from flops); there is no combinational path from hit to any output.

Reset
REQ-027 On a clk edge with resetn=0, state SHALL become ARMED, with the following values:
- hitAck=0, score=0, misses=0;
- all frame counters=0;
- lfsr=LFSR_SEED;
- targetCoord_X=320, targetCoord_Y=240.
REQ-028 Reset SHALL take priority over frame_tick, hit and any in-progress CONFIRM/ACK/COOLDOWN; a hitAck pending in that cycle SHALL be suppressed.
REQ-029 armed SHALL read 1 in the first cycle after reset release.

Structure
REQ-030 A shared package hit_pkg SHALL hold:
- the FSM state encoding;
- the coordinate width (12) and score width (14);
- the reset centre (320, 240);
- the coordinate offset (64);
- the saturation limit (9999).
REQ-031 The LFSR SHALL be a separate sub-module lfsr16, with ports clk, resetn, seed, and q[15:0].

Verification
REQ-032 Hit held high for 3 ticks from ARMED -> exactly one hitAck pulse 1 cycle after the 3rd tick; score 0->1; coordinates change; armed=0 for 30 ticks, then 1.
REQ-033 Hit high for 2 ticks, low on the 3rd -> no hitAck; state returns to ARMED; score stays 0.
REQ-034 Hit low for 300 ticks after reset -> misses=1 on the 300th tick; new coordinates within X 64..575 and Y 64..319; no hitAck.
REQ-035 Hit high on tick 300 of the timeout -> misses stays 0; hitAck follows after 3 ticks of hit.
REQ-036 Score preloaded to 9999 via forced hits -> a further confirmed hit pulses hitAck and score stays 9999.
REQ-037 resetn=0 for one cycle mid-COOLDOWN -> next cycle armed=1, score=0, coordinates (320,240), hitAck=0.
